// File: rtl/linked_list_pkg.sv
// Shared linked-list engine definitions: opcodes, widths, head-table entry
// layout and the head-table controller state encoding.
package linked_list;

  localparam int LL_KEY_WIDTH      = 32;
  localparam int LL_HEAD_PTR_WIDTH = 10;

  localparam logic [1:0] LL_OP_INSERT = 2'd0;
  localparam logic [1:0] LL_OP_DELETE = 2'd1;
  localparam logic [1:0] LL_OP_DEQ    = 2'd2;

  typedef struct packed {
    logic [LL_HEAD_PTR_WIDTH-1:0] ptr;
    logic                         val;
  } ll_head_entry_t;

  typedef enum logic [2:0] {
    HT_IDLE,
    HT_RD_WAIT,
    HT_ISSUE,
    HT_WAIT_RES,
    HT_CLEAR
  } ht_state_e;

endpackage

// File: rtl/ll_head_ram.sv
// Simple dual-port head RAM. A read that hits the address being written in
// the same cycle returns the new data. REGISTER_OUT adds an output stage,
// making the read latency two cycles instead of one.
module ll_head_ram #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 11,
  parameter bit REGISTER_OUT = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q, rd_d;

  // Array write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port with write-first forwarding on an address match.
  always_comb begin
    rd_d = rd_q;
    if (re_i) rd_d = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

  // Read data register.
  always_ff @(posedge clk_i) begin
    rd_q <= rd_d;
  end

  if (REGISTER_OUT) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_q;
    // Optional output register stage.
    always_ff @(posedge clk_i) begin
      out_q <= rd_q;
    end
    assign rdata_o = out_q;
  end else begin : g_out_comb
    assign rdata_o = rd_q;
  end

endmodule

// File: rtl/ll_head_table.sv
// Head-pointer table in front of the linked-list engine. Looks up the bucket
// head for each command, issues it to the engine, and applies the engine's
// write-back. One command in flight at a time keeps buckets atomic.
// Optional: LL_HEAD_TABLE_OCCUPANCY_EN adds occupied_cnt_o (non-empty buckets).
//
// state     | meaning
// IDLE      | ready for a command or a clear request
// RD_WAIT   | head RAM read in flight, RAM_LATENCY cycles
// ISSUE     | command presented to the engine until accepted
// WAIT_RES  | engine working; head write-backs applied to latched bucket
// CLEAR     | zeroing every bucket, one per cycle
module ll_head_table
  import linked_list::*;
#(
  parameter int BUCKET_WIDTH   = 8,
  parameter int KEY_WIDTH      = LL_KEY_WIDTH,
  parameter int HEAD_PTR_WIDTH = LL_HEAD_PTR_WIDTH,
  parameter int RAM_LATENCY    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [KEY_WIDTH-1:0]      cmd_key_i,
  input  logic [1:0]                cmd_opcode_i,
  input  logic [BUCKET_WIDTH-1:0]   cmd_bucket_i,
  output logic                      ll_cmd_valid_o,
  input  logic                      ll_cmd_ready_i,
  output logic [KEY_WIDTH-1:0]      ll_cmd_key_o,
  output logic [1:0]                ll_cmd_opcode_o,
  output logic [HEAD_PTR_WIDTH-1:0] ll_cmd_head_ptr_o,
  output logic                      ll_cmd_head_ptr_val_o,
  input  logic                      ll_res_valid_i,
  input  logic                      ll_res_ready_i,
  input  logic [HEAD_PTR_WIDTH-1:0] head_wr_data_ptr_i,
  input  logic                      head_wr_data_ptr_val_i,
  input  logic                      head_wr_en_i,
  input  logic                      clear_run_i,
  output logic                      clear_done_o
`ifdef LL_HEAD_TABLE_OCCUPANCY_EN
  ,
  output logic [BUCKET_WIDTH:0]     occupied_cnt_o
`endif
);

  ht_state_e             state_q, state_d;
  logic [KEY_WIDTH-1:0]    key_q, key_d;
  logic [1:0]              opcode_q, opcode_d;
  logic [BUCKET_WIDTH-1:0] bucket_q, bucket_d;
  ll_head_entry_t          head_q, head_d;
  logic [1:0]              lat_cnt_q, lat_cnt_d;
  logic [BUCKET_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  logic                    ram_we, ram_re;
  logic [BUCKET_WIDTH-1:0] ram_waddr;
  ll_head_entry_t          ram_wdata, ram_rdata;

  logic cmd_acc, res_hs, wb_apply, rd_capture, clr_last;

  assign cmd_acc    = cmd_valid_i && cmd_ready_o;
  assign res_hs     = ll_res_valid_i && ll_res_ready_i;
  assign wb_apply   = (state_q == HT_WAIT_RES) && head_wr_en_i;
  assign rd_capture = (state_q == HT_RD_WAIT) && (lat_cnt_q == 2'd0);
  assign clr_last   = (clr_cnt_q == '1);

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= HT_IDLE;
      key_q     <= '0;
      opcode_q  <= '0;
      bucket_q  <= '0;
      head_q    <= '0;
      lat_cnt_q <= '0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      opcode_q  <= opcode_d;
      bucket_q  <= bucket_d;
      head_q    <= head_d;
      lat_cnt_q <= lat_cnt_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic; a clear request outranks a pending command.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HT_IDLE:     if (clear_run_i) state_d = HT_CLEAR;
                   else if (cmd_valid_i) state_d = HT_RD_WAIT;
      HT_RD_WAIT:  if (lat_cnt_q == 2'd0) state_d = HT_ISSUE;
      HT_ISSUE:    if (ll_cmd_ready_i) state_d = HT_WAIT_RES;
      HT_WAIT_RES: if (res_hs) state_d = HT_IDLE;
      HT_CLEAR:    if (!clear_run_i && clr_last) state_d = HT_IDLE;
      default:     state_d = HT_IDLE;
    endcase
  end

  // Handshake outputs and RAM port control decoded from the state.
  always_comb begin
    cmd_ready_o    = (state_q == HT_IDLE) && !clear_run_i && !rst_i;
    ll_cmd_valid_o = (state_q == HT_ISSUE);
    clear_done_o   = (state_q == HT_CLEAR) && clr_last && !clear_run_i;
    ram_re         = cmd_acc;
    ram_we         = 1'b0;
    ram_waddr      = bucket_q;
    ram_wdata      = '{ptr: head_wr_data_ptr_i, val: head_wr_data_ptr_val_i};
    if (state_q == HT_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt_q;
      ram_wdata = '0;
    end else if (wb_apply) begin
      ram_we = 1'b1;
    end
  end

  // Command latch, read-latency down-counter and clear sweep counter.
  always_comb begin
    key_d     = key_q;
    opcode_d  = opcode_q;
    bucket_d  = bucket_q;
    head_d    = head_q;
    lat_cnt_d = lat_cnt_q;
    clr_cnt_d = clr_cnt_q;
    if (cmd_acc) begin
      key_d     = cmd_key_i;
      opcode_d  = cmd_opcode_i;
      bucket_d  = cmd_bucket_i;
      lat_cnt_d = 2'(RAM_LATENCY - 1);
    end
    if (rd_capture) head_d = ram_rdata;
    else if (state_q == HT_RD_WAIT) lat_cnt_d = lat_cnt_q - 2'd1;
    if ((state_q == HT_IDLE) && clear_run_i) clr_cnt_d = '0;
    else if (state_q == HT_CLEAR) begin
      if (clear_run_i) clr_cnt_d = '0;
      else if (!clr_last) clr_cnt_d = clr_cnt_q + 1'b1;
    end
  end

  assign ll_cmd_key_o          = key_q;
  assign ll_cmd_opcode_o       = opcode_q;
  assign ll_cmd_head_ptr_o     = head_q.ptr;
  assign ll_cmd_head_ptr_val_o = head_q.val;

  ll_head_ram #(
    .ADDR_WIDTH  (BUCKET_WIDTH),
    .DATA_WIDTH  ($bits(ll_head_entry_t)),
    .REGISTER_OUT(RAM_LATENCY == 2)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .re_i   (ram_re),
    .raddr_i(cmd_bucket_i),
    .rdata_o(ram_rdata)
  );

`ifdef LL_HEAD_TABLE_OCCUPANCY_EN
  logic                  last_val_q, last_val_d;
  logic [BUCKET_WIDTH:0] occ_q, occ_d;

  // Track the bucket's current valid flag so each write-back sees its transition.
  always_comb begin
    last_val_d = last_val_q;
    occ_d      = occ_q;
    if (rd_capture) last_val_d = ram_rdata.val;
    if (state_q == HT_CLEAR) begin
      occ_d = '0;
    end else if (wb_apply) begin
      last_val_d = head_wr_data_ptr_val_i;
      if (!last_val_q && head_wr_data_ptr_val_i) occ_d = occ_q + 1'b1;
      else if (last_val_q && !head_wr_data_ptr_val_i) occ_d = occ_q - 1'b1;
    end
  end

  // Occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_val_q <= 1'b0;
      occ_q      <= '0;
    end else begin
      last_val_q <= last_val_d;
      occ_q      <= occ_d;
    end
  end

  assign occupied_cnt_o = occ_q;
`endif

`ifndef SYNTHESIS
  // Write-backs outside WAIT_RES are dropped by design; flag them in simulation.
  a_wb_in_wait_res : assert property (@(posedge clk_i) disable iff (rst_i)
    head_wr_en_i |-> (state_q == HT_WAIT_RES))
    else $error("ll_head_table: head write-back outside WAIT_RES ignored");
`endif

endmodule
